// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and restoring
// divide over 32 iterations, with sign pre/post-correction and RISC-V corner cases.
module muldiv_sequencer #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] A,
  input  logic [XLEN-1:0] B,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int unsigned CNT_W = 6;
  localparam int unsigned ACC_W = 2 * XLEN;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(XLEN - 1);
  localparam logic [XLEN-1:0]  INT_MIN   = {1'b1, {(XLEN - 1){1'b0}}};
  localparam logic [XLEN-1:0]  ALL_ONES  = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [2:0]        op_q, op_d;
  logic              neg_a_q, neg_a_d;
  logic              neg_b_q, neg_b_d;
  logic              div0_q, div0_d;
  logic              ovf_q, ovf_d;
  logic [XLEN-1:0]   opa_q, opa_d;
  logic [XLEN-1:0]   opb_q, opb_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              done_q, done_d;
  logic [XLEN-1:0]   result_q, result_d;

  // Operand signedness decoded from the incoming funct3
  logic a_signed, b_signed;
  assign a_signed = (funct3 == 3'b001) || (funct3 == 3'b010) ||
                    (funct3 == 3'b100) || (funct3 == 3'b110);
  assign b_signed = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);

  logic              is_div;
  logic [XLEN:0]     mul_sum;
  logic [ACC_W-1:0]  mul_acc;
  logic [XLEN:0]     div_shift;
  logic              div_ge;
  logic [XLEN-1:0]   div_sub;
  logic [ACC_W-1:0]  div_acc;
  logic [ACC_W-1:0]  step_acc;
  logic [ACC_W-1:0]  prod_fix;
  logic [XLEN-1:0]   quo, rem, quo_fix, rem_fix;
  logic [XLEN-1:0]   final_res;

  assign is_div = op_q[2];

  // Multiply step: conditional add into the upper half, then shift {carry, acc} right
  assign mul_sum = {1'b0, acc_q[ACC_W-1:XLEN]} + (opb_q[0] ? {1'b0, opa_q} : '0);
  assign mul_acc = {mul_sum, acc_q[XLEN-1:1]};

  // Divide step: shift the next dividend bit into rem, keep the difference if no underflow
  assign div_shift = {acc_q[ACC_W-1:XLEN], opa_q[XLEN-1]};
  assign div_ge    = div_shift >= {1'b0, opb_q};
  assign div_sub   = div_shift[XLEN-1:0] - opb_q;
  assign div_acc   = {(div_ge ? div_sub : div_shift[XLEN-1:0]), acc_q[XLEN-2:0], div_ge};

  assign step_acc = is_div ? div_acc : mul_acc;
  assign prod_fix = (neg_a_q ^ neg_b_q) ? -step_acc : step_acc;
  assign quo      = step_acc[XLEN-1:0];
  assign rem      = step_acc[ACC_W-1:XLEN];
  assign quo_fix  = (neg_a_q ^ neg_b_q) ? -quo : quo;
  assign rem_fix  = neg_a_q ? -rem : rem;

  // Final result selection; divide-by-zero REM/REMU naturally yields A through the rem path
  always_comb begin
    final_res = '0;
    case (op_q)
      3'b000:                 final_res = prod_fix[XLEN-1:0];
      3'b001, 3'b010, 3'b011: final_res = prod_fix[ACC_W-1:XLEN];
      3'b100:                 final_res = div0_q ? ALL_ONES : (ovf_q ? INT_MIN : quo_fix);
      3'b101:                 final_res = div0_q ? ALL_ONES : quo;
      3'b110:                 final_res = ovf_q ? '0 : rem_fix;
      default:                final_res = rem;
    endcase
  end

  // Control FSM next-state and datapath updates
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    neg_a_d  = neg_a_q;
    neg_b_d  = neg_b_q;
    div0_d   = div0_q;
    ovf_d    = ovf_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    result_d = result_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          op_d    = funct3;
          neg_a_d = a_signed && A[XLEN-1];
          neg_b_d = b_signed && B[XLEN-1];
          opa_d   = (a_signed && A[XLEN-1]) ? -A : A;
          opb_d   = (b_signed && B[XLEN-1]) ? -B : B;
          div0_d  = (B == '0);
          ovf_d   = (A == INT_MIN) && (B == ALL_ONES);
          acc_d   = '0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        acc_d = step_acc;
        cnt_d = cnt_q + CNT_W'(1);
        if (is_div) begin
          opa_d = {opa_q[XLEN-2:0], 1'b0};
        end else begin
          opb_d = {1'b0, opb_q[XLEN-1:1]};
        end
        if (cnt_q == LAST_ITER) begin
          state_d  = DONE;
          done_d   = 1'b1;
          result_d = final_res;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      op_q     <= '0;
      neg_a_q  <= 1'b0;
      neg_b_q  <= 1'b0;
      div0_q   <= 1'b0;
      ovf_q    <= 1'b0;
      opa_q    <= '0;
      opb_q    <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      neg_a_q  <= neg_a_d;
      neg_b_q  <= neg_b_d;
      div0_q   <= div0_d;
      ovf_q    <= ovf_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
      result_q <= result_d;
    end
  end

  assign busy   = (state_q != IDLE);
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: directed RV32M vectors plus randomized
// traffic checked every cycle against a timeline/arithmetic reference model.
module tb_muldiv_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  funct3 = 3'd0;
  logic [31:0] op_a = 32'd0;
  logic [31:0] op_b = 32'd0;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int errors = 0;
  int checks = 0;
  logic cmp_en = 1'b0;

  muldiv_sequencer #(.XLEN(32)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .funct3 (funct3),
    .A      (op_a),
    .B      (op_b),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;

  // Reference arithmetic straight from the RV32M definitions
  function automatic logic [31:0] ref_op(input logic [2:0] f, input logic [31:0] a,
                                         input logic [31:0] b);
    logic [63:0] p;
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    p = 64'd0;
    case (f)
      3'd0: begin p = {32'd0, a} * {32'd0, b}; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * longint'({32'd0, b}); return p[63:32]; end
      3'd3: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
      3'd4: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return $signed(a) / $signed(b);
      end
      3'd5: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        return a / b;
      end
      3'd6: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return $signed(a) % $signed(b);
      end
      default: begin
        if (b == 32'd0) return a;
        return a % b;
      end
    endcase
  endfunction

  // Timeline model: age 0 = idle, 1..32 = running, 33 = done cycle
  int          m_age = 0;
  logic [31:0] m_pend = 32'd0;
  logic [31:0] m_result = 32'd0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_age    <= 0;
      m_result <= 32'd0;
    end else if (m_age == 0) begin
      if (start) begin
        m_age  <= 1;
        m_pend <= ref_op(funct3, op_a, op_b);
      end
    end else if (m_age == 33) begin
      m_age <= 0;
    end else begin
      m_age <= m_age + 1;
      if (m_age == 32) m_result <= m_pend;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the model
  logic prev_done = 1'b0;
  always @(negedge clk) begin
    if (cmp_en && !reset) begin
      chk("cyc_busy", {31'd0, busy}, {31'd0, (m_age != 0)});
      chk("cyc_done", {31'd0, done}, {31'd0, (m_age == 33)});
      chk("cyc_result", result, m_result);
      if (done) chk("done_width", {31'd0, prev_done}, 32'd0);
    end
    prev_done = done;
  end

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if (!busy) ok = 1'b1;
    end
    if (!ok) chk("wait_idle_timeout", 32'd1, 32'd0);
  endtask

  task automatic do_op(input string name, input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp, input bit noise);
    bit got;
    int lat;
    wait_idle();
    funct3 = f; op_a = a; op_b = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    op_a = $urandom; op_b = $urandom; funct3 = 3'($urandom);
    got = 1'b0;
    lat = 0;
    for (int k = 1; k <= 40 && !got; k++) begin
      start = (noise && k == 5);
      @(negedge clk);
      if (done) begin got = 1'b1; lat = k; end
    end
    start = 1'b0;
    chk({name, "_seen_done"}, {31'd0, got}, 32'd1);
    chk({name, "_latency"}, lat, 32'd32);
    chk(name, result, exp);
    if (noise) begin
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk({name, "_hold"}, result, exp);
      chk({name, "_idle_after_done"}, {31'd0, busy}, 32'd0);
    end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 6))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_result", result, 32'd0);
    reset = 1'b0;
    cmp_en = 1'b1;

    do_op("mul", 3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0);
    do_op("mulh", 3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b1);
    do_op("mulhu", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0);
    do_op("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    do_op("div", 3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b1);
    do_op("rem", 3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b0);
    do_op("divu", 3'd5, 32'd100, 32'd7, 32'd14, 1'b0);
    do_op("remu", 3'd7, 32'd100, 32'd7, 32'd2, 1'b1);
    do_op("div_by0", 3'd4, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b0);
    do_op("rem_by0", 3'd6, 32'd5, 32'd0, 32'd5, 1'b0);
    do_op("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0);
    do_op("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b0);
    do_op("divu_pre_rst", 3'd5, 32'd100, 32'd7, 32'd14, 1'b0);

    // Back-to-back: start held high with fresh operands every cycle
    start = 1'b1;
    for (int i = 0; i < 3 * 34; i++) begin
      funct3 = 3'($urandom); op_a = pick(); op_b = pick();
      @(negedge clk);
    end
    start = 1'b0;

    // Randomized traffic: random start noise and operand churn
    for (int i = 0; i < 220 * 34; i++) begin
      start  = ($urandom_range(0, 3) == 0);
      funct3 = 3'($urandom);
      op_a   = pick();
      op_b   = pick();
      @(negedge clk);
    end
    start = 1'b0;

    // Asynchronous reset in the middle of a DIVU
    do_op("divu_pre_rst2", 3'd5, 32'd100, 32'd7, 32'd14, 1'b0);
    wait_idle();
    funct3 = 3'd5; op_a = 32'd1_000_000; op_b = 32'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_busy", {31'd0, busy}, 32'd0);
    chk("async_rst_done", {31'd0, done}, 32'd0);
    chk("async_rst_result", result, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    do_op("mul_after_rst", 3'd0, 32'd3, 32'd4, 32'd12, 1'b0);

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    errors++;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog expired");
  end

endmodule
